// File: rtl/led_counter_ctrl.sv
// Prescaled up/down LED counter; KEY_RUN/KEY_DIR presses toggle run and direction (build option LED_GRAY_EN: Gray-coded LEDs).
// Latency: press acts on edge DEBOUNCE_CYCLES+2 after first low sample; COUNT/LED/WRAP registered, one edge per step.
// Backpressure: none, free-running; WRAP is a single-cycle strobe with no handshake.
module led_counter_ctrl #(
    parameter int CNT_WIDTH       = 32,
    parameter int LED_WIDTH       = 3,
    parameter int LED_LSB         = 23,
    parameter int PRESCALE        = 1,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                 CLK100MHZ,
    input  logic                 RESET_N,
    input  logic                 KEY_RUN,
    input  logic                 KEY_DIR,
    output logic [LED_WIDTH-1:0] LED,
    output logic [CNT_WIDTH-1:0] COUNT,
    output logic                 RUNNING,
    output logic                 DIR_DOWN,
    output logic                 WRAP
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [DB_W-1:0]      DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]      DB_ONE  = DB_W'(1);
    localparam logic [PS_W-1:0]      PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0]      PS_ONE  = PS_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [1:0] w_key_raw;
    logic [1:0] w_press;

    assign w_key_raw = {KEY_DIR, KEY_RUN};

    // Bit 0 = run key, bit 1 = direction key; both share the same synchroniser + debounce.
    for (genvar k = 0; k < 2; k++) begin : g_key
        logic            r_sync1;
        logic            r_sync2;
        logic            r_deb;
        logic [DB_W-1:0] r_dcnt;
        logic            w_diff;
        logic            w_accept;

        assign w_diff   = r_sync2 ^ r_deb;
        assign w_accept = w_diff && (r_dcnt == DB_LAST);

        always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
            if (!RESET_N) begin
                r_sync1 <= 1'b1;
                r_sync2 <= 1'b1;
                r_deb   <= 1'b1;
                r_dcnt  <= '0;
            end else begin
                r_sync1 <= w_key_raw[k];
                r_sync2 <= r_sync1;
                if (!w_diff) begin
                    r_dcnt <= '0;
                end else if (w_accept) begin
                    r_deb  <= r_sync2;
                    r_dcnt <= '0;
                end else begin
                    r_dcnt <= r_dcnt + DB_ONE;
                end
            end
        end

        // Press is the accepted 1->0 transition, flagged on the edge that accepts it.
        assign w_press[k] = w_accept && !r_sync2;
    end

    logic [PS_W-1:0]      r_presc;
    logic                 r_running;
    logic                 r_dir_down;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_wrap;
    logic [LED_WIDTH-1:0] r_led;

    logic                 w_tick;
    logic                 w_wrap;
    logic [CNT_WIDTH-1:0] w_count_nxt;
    logic [LED_WIDTH-1:0] w_slice;
    logic [LED_WIDTH-1:0] w_led_nxt;

    assign w_tick = r_running && (r_presc == PS_LAST);

    always_comb begin
        w_count_nxt = r_count;
        w_wrap      = 1'b0;
        if (w_tick) begin
            if (r_dir_down) begin
                w_count_nxt = r_count - CNT_ONE;
                w_wrap      = (r_count == '0);
            end else begin
                w_count_nxt = r_count + CNT_ONE;
                w_wrap      = &r_count;
            end
        end
    end

    assign w_slice = w_count_nxt[LED_LSB +: LED_WIDTH];

`ifdef LED_GRAY_EN
    assign w_led_nxt = w_slice ^ (w_slice >> 1);
`else
    assign w_led_nxt = w_slice;
`endif

    // Prescaler phase is frozen while paused so a resume finishes the interrupted period.
    always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            r_presc <= '0;
        end else if (r_running) begin
            r_presc <= w_tick ? '0 : (r_presc + PS_ONE);
        end
    end

    always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            r_running  <= 1'b1;
            r_dir_down <= 1'b0;
            r_count    <= '0;
            r_wrap     <= 1'b0;
            r_led      <= '0;
        end else begin
            r_running  <= r_running ^ w_press[0];
            r_dir_down <= r_dir_down ^ w_press[1];
            r_count    <= w_count_nxt;
            r_wrap     <= w_wrap;
            r_led      <= w_led_nxt;
        end
    end

    assign COUNT    = r_count;
    assign LED      = r_led;
    assign RUNNING  = r_running;
    assign DIR_DOWN = r_dir_down;
    assign WRAP     = r_wrap;

endmodule

// File: tb/tb_led_counter_ctrl.sv
// Bench for led_counter_ctrl: two instances (PRESCALE 1 and 4) on shared keys, checked each cycle against an arithmetic model.
module tb_led_counter_ctrl;

    localparam int CW   = 8;
    localparam int LW   = 3;
    localparam int LL   = 5;
    localparam int DB   = 4;
    localparam int PS_B = 4;
    localparam int MOD  = 256;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          key_run = 1'b1;
    logic          key_dir = 1'b1;
    logic [LW-1:0] led_a, led_b;
    logic [CW-1:0] cnt_a, cnt_b;
    logic          run_a, run_b, dir_a, dir_b, wrap_a, wrap_b;

    int n_cmp    = 0;
    int n_bad    = 0;
    int n_wrap_a = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    led_counter_ctrl #(
        .CNT_WIDTH(CW), .LED_WIDTH(LW), .LED_LSB(LL), .PRESCALE(1), .DEBOUNCE_CYCLES(DB)
    ) u_dut_a (
        .CLK100MHZ(clk), .RESET_N(rst_n), .KEY_RUN(key_run), .KEY_DIR(key_dir),
        .LED(led_a), .COUNT(cnt_a), .RUNNING(run_a), .DIR_DOWN(dir_a), .WRAP(wrap_a)
    );

    led_counter_ctrl #(
        .CNT_WIDTH(CW), .LED_WIDTH(LW), .LED_LSB(LL), .PRESCALE(PS_B), .DEBOUNCE_CYCLES(DB)
    ) u_dut_b (
        .CLK100MHZ(clk), .RESET_N(rst_n), .KEY_RUN(key_run), .KEY_DIR(key_dir),
        .LED(led_b), .COUNT(cnt_b), .RUNNING(run_b), .DIR_DOWN(dir_b), .WRAP(wrap_b)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int led_of(input int c);
        int s;
        s = (c / (2 ** LL)) % (2 ** LW);
`ifdef LED_GRAY_EN
        s = s ^ (s / 2);
`endif
        return s;
    endfunction

    // Reference model: counts as plain integers, keys as sampled histories.
    int m_s1[2], m_s2[2], m_deb[2], m_dc[2];
    int m_run, m_dir, m_cnt_a, m_cnt_b, m_act_b, m_wrap_a, m_wrap_b;

    always @(posedge clk or negedge rst_n) begin : p_model
        int  press[2];
        int  v;
        int  step;
        bit  tick_b;
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_s1[k] = 1; m_s2[k] = 1; m_deb[k] = 1; m_dc[k] = 0;
            end
            m_run = 1; m_dir = 0; m_cnt_a = 0; m_cnt_b = 0;
            m_act_b = 0; m_wrap_a = 0; m_wrap_b = 0;
        end else begin
            step = (m_dir != 0) ? -1 : 1;
            if (m_run != 0) begin
                v = m_cnt_a + step;
                m_wrap_a = (v < 0 || v >= MOD) ? 1 : 0;
                m_cnt_a  = (v + MOD) % MOD;
            end else begin
                m_wrap_a = 0;
            end
            tick_b = (m_run != 0) && ((m_act_b % PS_B) == PS_B - 1);
            if (tick_b) begin
                v = m_cnt_b + step;
                m_wrap_b = (v < 0 || v >= MOD) ? 1 : 0;
                m_cnt_b  = (v + MOD) % MOD;
            end else begin
                m_wrap_b = 0;
            end
            if (m_run != 0) m_act_b++;
            for (int k = 0; k < 2; k++) begin
                press[k] = 0;
                if (m_s2[k] != m_deb[k]) begin
                    m_dc[k]++;
                    if (m_dc[k] == DB) begin
                        m_deb[k] = m_s2[k];
                        m_dc[k]  = 0;
                        press[k] = (m_deb[k] == 0) ? 1 : 0;
                    end
                end else begin
                    m_dc[k] = 0;
                end
                m_s2[k] = m_s1[k];
            end
            m_s1[0] = int'(key_run);
            m_s1[1] = int'(key_dir);
            m_run = m_run ^ press[0];
            m_dir = m_dir ^ press[1];
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("count_a", int'(cnt_a), m_cnt_a);
            chk("led_a",   int'(led_a), led_of(m_cnt_a));
            chk("run_a",   int'(run_a), m_run);
            chk("dir_a",   int'(dir_a), m_dir);
            chk("wrap_a",  int'(wrap_a), m_wrap_a);
            chk("count_b", int'(cnt_b), m_cnt_b);
            chk("led_b",   int'(led_b), led_of(m_cnt_b));
            chk("run_b",   int'(run_b), m_run);
            chk("dir_b",   int'(dir_b), m_dir);
            chk("wrap_b",  int'(wrap_b), m_wrap_b);
            if (wrap_a) n_wrap_a++;
        end
    end

    task automatic hold(input logic r, input logic d, input int n);
        key_run = r;
        key_dir = d;
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count_a"}, int'(cnt_a), 0);
        chk({tag, "_count_b"}, int'(cnt_b), 0);
        chk({tag, "_led_a"},   int'(led_a), 0);
        chk({tag, "_run_a"},   int'(run_a), 1);
        chk({tag, "_dir_a"},   int'(dir_a), 0);
        chk({tag, "_wrap_a"},  int'(wrap_a), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_reset_state("rst");
        chk_en = 1'b1;
        rst_n  = 1'b1;

        @(negedge clk);
        chk("first_step", int'(cnt_a), 1);
        repeat (300) @(negedge clk);
        chk("wrap_pulses", n_wrap_a, 1);

        // Run key held low: RUNNING drops on edge DB+2.
        key_run = 1'b0;
        repeat (DB + 1) @(negedge clk);
        chk("run_before_accept", int'(run_a), 1);
        @(negedge clk);
        chk("run_after_accept", int'(run_a), 0);
        hold(1'b0, 1'b1, 4);
        hold(1'b1, 1'b1, 15);
        hold(1'b0, 1'b1, 8);
        hold(1'b1, 1'b1, 10);
        chk("resume", int'(run_a), 1);

        // Bouncy press never accepted.
        hold(1'b0, 1'b1, 3);
        hold(1'b1, 1'b1, 1);
        hold(1'b0, 1'b1, 3);
        hold(1'b1, 1'b1, 12);
        chk("bounce_run", int'(run_a), 1);

        hold(1'b1, 1'b0, 8);
        hold(1'b1, 1'b1, 300);
        chk("dir_down", int'(dir_a), 1);

        // Pause mid prescale period, then resume.
        hold(1'b1, 1'b1, 1);
        hold(1'b0, 1'b1, 7);
        hold(1'b1, 1'b1, 10);
        hold(1'b0, 1'b1, 7);
        hold(1'b1, 1'b1, 20);

        // Both keys at once toggle both controls.
        hold(1'b0, 1'b0, 8);
        hold(1'b1, 1'b1, 10);
        chk("both_run", int'(run_a), 0);
        chk("both_dir", int'(dir_a), 0);
        hold(1'b0, 1'b1, 8);
        hold(1'b1, 1'b1, 40);

        // Asynchronous reset mid-debounce, between clock edges.
        hold(1'b0, 1'b1, 4);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_state("arst");
        key_run = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 90; i++) begin
            int mode;
            mode = $urandom_range(0, 3);
            case (mode)
                0: hold(1'b0, 1'b1, $urandom_range(1, 8));
                1: hold(1'b1, 1'b0, $urandom_range(1, 8));
                2: hold(1'b0, 1'b0, $urandom_range(1, 8));
                default: hold(1'b1, 1'b1, $urandom_range(1, 8));
            endcase
            hold(1'b1, 1'b1, $urandom_range(1, 12));
        end
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
